// File: rtl/rddata_bitcell_decoder.sv
// Recovers IWM read bits from raw rddata flux transitions using bit-cell window timing.
// Optional build macro RDDATA_GLITCH_FILTER_EN rejects transitions arriving before half a cell.
module rddata_bitcell_decoder #(
   parameter int CELL_CLKS   = 28,
   parameter int SYNC_STAGES = 2
) (
   input  logic       fclk,
   input  logic       _reset,
   input  logic       rddata,
   input  logic       enable,
   input  logic       fast,
   output logic       bit_strobe,
   output logic       bit_value,
   output logic [5:0] timer,
   output logic       tracking,
   output logic       glitch
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HUNT  = 2'd1,
      TRACK = 2'd2
   } state_t;

   localparam logic [5:0] C_SLOW    = 6'(CELL_CLKS);
   localparam logic [5:0] C_FAST    = 6'(CELL_CLKS / 2);
   localparam logic [5:0] H_SLOW    = C_SLOW >> 1;
   localparam logic [5:0] H_FAST    = C_FAST >> 1;
   localparam logic [5:0] WEND_SLOW = C_SLOW + H_SLOW - 6'd1;
   localparam logic [5:0] WEND_FAST = C_FAST + H_FAST - 6'd1;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   fall_q;
   logic                   fall_pend;
   logic                   fast_q;
   logic [2:0]             zero_cnt;

   logic [5:0] half_len;
   logic [5:0] win_last;
   logic       fall_evt;
   logic       early;
   logic       take_one;
   logic       take_zero;

   assign half_len = fast_q ? H_FAST : H_SLOW;
   assign win_last = fast_q ? WEND_FAST : WEND_SLOW;

   // A transition seen while a strobe is on the output is held one cycle so strobes never abut.
   assign fall_evt = fall_q | fall_pend;

`ifdef RDDATA_GLITCH_FILTER_EN
   assign early = (timer < half_len);
`else
   assign early = 1'b0;
`endif

   assign take_one  = fall_evt & ~bit_strobe & ~early;
   assign take_zero = ~fall_evt & (timer == win_last);

   // Line idles high, so the chain presets to 1 to avoid a false fall after reset.
   always_ff @(posedge fclk or negedge _reset) begin
      if (!_reset) begin
         sync_q <= '1;
         hist_q <= 1'b1;
         fall_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         sync_q <= {sync_q[SYNC_STAGES-2:0], rddata};
         hist_q <= sync_q[SYNC_STAGES-1];
         fall_q <= hist_q & ~sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge fclk or negedge _reset) begin
      if (!_reset) begin
         state      <= IDLE;
         bit_strobe <= 1'b0;
         bit_value  <= 1'b0;
         timer      <= 6'd0;
         tracking   <= 1'b0;
         fall_pend  <= 1'b0;
         fast_q     <= 1'b0;
         zero_cnt   <= 3'd0;
      end else begin
         bit_strobe <= 1'b0;
         if (!enable) begin
            state     <= IDLE;
            timer     <= 6'd0;
            tracking  <= 1'b0;
            fall_pend <= 1'b0;
            zero_cnt  <= 3'd0;
         end else begin
            case (state)
               IDLE: begin
                  state  <= HUNT;
                  fast_q <= fast;
                  timer  <= 6'd0;
               end
               HUNT: begin
                  timer     <= 6'd0;
                  fast_q    <= fast;
                  fall_pend <= 1'b0;
                  if (fall_q) begin
                     state      <= TRACK;
                     tracking   <= 1'b1;
                     bit_strobe <= 1'b1;
                     bit_value  <= 1'b1;
                     zero_cnt   <= 3'd0;
                  end
               end
               TRACK: begin
                  fall_pend <= fall_evt & bit_strobe;
                  if (take_one) begin
                     bit_strobe <= 1'b1;
                     bit_value  <= 1'b1;
                     timer      <= 6'd0;
                     zero_cnt   <= 3'd0;
                  end else if (take_zero) begin
                     bit_strobe <= 1'b1;
                     bit_value  <= 1'b0;
                     if (zero_cnt == 3'd7) begin
                        state    <= HUNT;
                        tracking <= 1'b0;
                        timer    <= 6'd0;
                        zero_cnt <= 3'd0;
                     end else begin
                        // Reloading H places the next empty-window decision one full cell later.
                        timer    <= half_len;
                        zero_cnt <= zero_cnt + 3'd1;
                     end
                  end else begin
                     timer <= (timer == 6'd63) ? timer : timer + 6'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef RDDATA_GLITCH_FILTER_EN
   always_ff @(posedge fclk or negedge _reset) begin
      if (!_reset) begin
         glitch <= 1'b0;
      end else begin
         glitch <= enable & (state == TRACK) & fall_evt & ~bit_strobe & early;
      end
   end
`else
   assign glitch = 1'b0;
`endif

endmodule

// File: tb/tb_rddata_bitcell_decoder.sv
// Scoreboard bench for rddata_bitcell_decoder: directed flux edges, expected bits queued with their cycle.
module tb_rddata_bitcell_decoder;

   logic       fclk = 1'b0;
   logic       _reset;
   logic       rddata;
   logic       enable;
   logic       fast;
   logic       bit_strobe;
   logic       bit_value;
   logic [5:0] timer;
   logic       tracking;
   logic       glitch;

   rddata_bitcell_decoder #(.CELL_CLKS(28), .SYNC_STAGES(2)) dut (
      .fclk       (fclk),
      ._reset     (_reset),
      .rddata     (rddata),
      .enable     (enable),
      .fast       (fast),
      .bit_strobe (bit_strobe),
      .bit_value  (bit_value),
      .timer      (timer),
      .tracking   (tracking),
      .glitch     (glitch)
   );

   always #5 fclk = ~fclk;

   typedef struct {
      bit v;
      int at;
      int tmr;
   } exp_t;

   exp_t  exp_q[$];
   int    cyc = 0;
   int    tests = 0;
   int    fails = 0;
   int    glitch_cnt = 0;
   bit    prev_strobe = 1'b0;
   string phase = "reset";

   always @(posedge fclk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s/%s: got %0d, expected %0d (cycle %0d)", phase, name, act, req, cyc);
      end
   endtask

   // Monitor: pops one expectation per strobe and compares value, cycle and timer.
   always @(negedge fclk) begin
      if (_reset) begin
         if (glitch) glitch_cnt++;
         if (bit_strobe) begin
            if (prev_strobe) begin
               tests++;
               fails++;
               $display("FAIL %s/strobe_gap: strobes in consecutive cycles at cycle %0d", phase, cyc);
            end
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL %s/unexpected_strobe: value %0d at cycle %0d, none expected", phase, bit_value, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("bit_value", int'(bit_value), int'(e.v));
               check("strobe_cycle", cyc, e.at);
               if (e.tmr >= 0) check("strobe_timer", int'(timer), e.tmr);
            end
         end
         prev_strobe = bit_strobe;
      end else begin
         prev_strobe = 1'b0;
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge fclk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic push(input bit v, input int at, input int tmr);
      exp_t e;
      e.v = v;
      e.at = at;
      e.tmr = tmr;
      exp_q.push_back(e);
   endtask

   task automatic edge_now();
      rddata = 1'b0;
      tick(1);
      rddata = 1'b1;
   endtask

   task automatic start(input bit f);
      fast = f;
      enable = 1'b1;
      tick(3);
   endtask

   task automatic stop();
      enable = 1'b0;
      tick(3);
      check("drained", exp_q.size(), 0);
   endtask

   task automatic check_all_reset();
      check("rst_strobe", int'(bit_strobe), 0);
      check("rst_value", int'(bit_value), 0);
      check("rst_timer", int'(timer), 0);
      check("rst_tracking", int'(tracking), 0);
      check("rst_glitch", int'(glitch), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int m;
      int g0;
      _reset = 1'b0;
      rddata = 1'b1;
      enable = 1'b0;
      fast   = 1'b0;
      #12;
      check_all_reset();
      tick(2);
      _reset = 1'b1;
      tick(2);

      // Ten transitions one slow cell apart: lock and ten 1 bits, first at edge+4.
      phase = "lock";
      start(1'b0);
      for (int i = 0; i < 10; i++) begin
         n = cyc;
         push(1'b1, n + 4, 0);
         edge_now();
         if (i < 9) tick(27);
      end
      tick(9);
      check("tracking_locked", int'(tracking), 1);
      stop();

      // Slow mode, edges three cells apart: 1,0,0,1 with zeros at timer 41.
      phase = "slow_gap";
      start(1'b0);
      n = cyc;
      push(1'b1, n + 4, 0);
      push(1'b0, n + 46, 14);
      push(1'b0, n + 74, 14);
      push(1'b1, n + 88, 0);
      edge_now();
      wait_until(n + 84);
      edge_now();
      wait_until(n + 100);
      stop();

      // Fast mode, edges 14 then 28 cycles apart: 1,1,0,1; the 0 decided at timer 20.
      phase = "fast";
      start(1'b1);
      n = cyc;
      push(1'b1, n + 4, 0);
      push(1'b1, n + 18, 0);
      push(1'b0, n + 39, 7);
      push(1'b1, n + 46, 0);
      edge_now();
      wait_until(n + 14);
      edge_now();
      wait_until(n + 42);
      edge_now();
      wait_until(n + 55);
      stop();

      // Extra transition 5 cycles after a valid one, next valid one a cell later.
      phase = "glitch";
      start(1'b0);
      g0 = glitch_cnt;
      n = cyc;
      push(1'b1, n + 4, 0);
`ifdef RDDATA_GLITCH_FILTER_EN
      push(1'b1, n + 32, 0);
`else
      push(1'b1, n + 9, 0);
      push(1'b1, n + 32, 0);
`endif
      edge_now();
      wait_until(n + 5);
      edge_now();
      wait_until(n + 28);
      edge_now();
      wait_until(n + 40);
`ifdef RDDATA_GLITCH_FILTER_EN
      check("glitch_count", glitch_cnt - g0, 1);
`else
      check("glitch_count", glitch_cnt - g0, 0);
`endif
      stop();

      // Silent line after lock: eight zeros, drop to HUNT, then re-lock on the next edge.
      phase = "runaway";
      start(1'b0);
      n = cyc;
      push(1'b1, n + 4, 0);
      for (int k = 0; k < 8; k++) push(1'b0, n + 46 + 28 * k, (k == 7) ? -1 : 14);
      edge_now();
      wait_until(n + 244);
      check("tracking_lost", int'(tracking), 0);
      wait_until(n + 300);
      check("no_ninth_zero", exp_q.size(), 0);
      m = cyc;
      push(1'b1, m + 4, 0);
      edge_now();
      wait_until(m + 8);
      check("tracking_relock", int'(tracking), 1);
      stop();

      // Enable dropped in the cycle a 0 is decided: no strobe, timer cleared.
      phase = "enable_drop";
      start(1'b0);
      n = cyc;
      push(1'b1, n + 4, 0);
      edge_now();
      wait_until(n + 45);
      enable = 1'b0;
      tick(1);
      check("drop_timer", int'(timer), 0);
      check("drop_strobe", int'(bit_strobe), 0);
      tick(2);
      check("drop_drained", exp_q.size(), 0);

      // Asynchronous reset mid-TRACK, then a fresh HUNT is needed for the next 1.
      phase = "mid_reset";
      start(1'b0);
      n = cyc;
      push(1'b1, n + 4, 0);
      edge_now();
      wait_until(n + 20);
      check("pre_reset_tracking", int'(tracking), 1);
      #2;
      _reset = 1'b0;
      #1;
      check_all_reset();
      tick(2);
      _reset = 1'b1;
      wait_until(n + 80);
      check("post_reset_tracking", int'(tracking), 0);
      m = cyc;
      push(1'b1, m + 4, 0);
      edge_now();
      wait_until(m + 10);
      check("post_reset_relock", int'(tracking), 1);
      stop();

      phase = "end";
      check("queue_empty_end", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
